// File: rtl/lsu_pkg.sv
// Shared state type, Funct3 width encodings and access-check helpers for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } lsu_state_e;

    localparam logic [2:0] Funct3Lb  = 3'b000;
    localparam logic [2:0] Funct3Lh  = 3'b001;
    localparam logic [2:0] Funct3Lw  = 3'b010;
    localparam logic [2:0] Funct3Lbu = 3'b100;
    localparam logic [2:0] Funct3Lhu = 3'b101;
    localparam logic [2:0] Funct3Sb  = 3'b000;
    localparam logic [2:0] Funct3Sh  = 3'b001;
    localparam logic [2:0] Funct3Sw  = 3'b010;

    // Funct3[1:0] carries the access size for every legal encoding.
    localparam logic [1:0] SizeByte = 2'b00;
    localparam logic [1:0] SizeHalf = 2'b01;

    localparam int unsigned DefaultTimeout = 255;

    function automatic logic access_legal(input logic       is_load,
                                          input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
        logic ok;
        ok = 1'b0;
        if (is_load) begin
            case (funct3)
                Funct3Lb, Funct3Lbu: ok = 1'b1;
                Funct3Lh, Funct3Lhu: ok = ~addr_lo[0];
                Funct3Lw:            ok = (addr_lo == 2'b00);
                default:             ok = 1'b0;
            endcase
        end else begin
            case (funct3)
                Funct3Sb: ok = 1'b1;
                Funct3Sh: ok = ~addr_lo[0];
                Funct3Sw: ok = (addr_lo == 2'b00);
                default:  ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    function automatic logic [3:0] byte_enable(input logic [1:0] size,
                                               input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            SizeByte: be = 4'b0001 << addr_lo;
            SizeHalf: be = 4'b0011 << addr_lo;
            default:  be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/halfword lane of a read word and sign- or zero-extends it.
module load_extend
    import lsu_pkg::*;
#(
    parameter int unsigned DATAWIDTH = 32
) (
    input  logic [DATAWIDTH-1:0] i_word,
    input  logic [1:0]           i_addr_lo,
    input  logic [2:0]           i_funct3,
    output logic [DATAWIDTH-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_word[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_word[{i_addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        o_data = i_word;
        case (i_funct3)
            Funct3Lb:  o_data = {{(DATAWIDTH - 8){w_byte[7]}}, w_byte};
            Funct3Lh:  o_data = {{(DATAWIDTH - 16){w_half[15]}}, w_half};
            Funct3Lbu: o_data = {{(DATAWIDTH - 8){1'b0}}, w_byte};
            Funct3Lhu: o_data = {{(DATAWIDTH - 16){1'b0}}, w_half};
            default:   o_data = i_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: alignment check, lane steering, memory handshake
// with a wait-cycle timeout.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned DATAWIDTH = 32,
    parameter int unsigned TIMEOUT   = DefaultTimeout
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 Valid_i,
    input  logic                 MemRead_i,
    input  logic                 MemWrite_i,
    input  logic [2:0]           Funct3_i,
    input  logic [DATAWIDTH-1:0] Addr_i,
    input  logic [DATAWIDTH-1:0] WriteData_i,
    output logic                 Ready_o,
    output logic                 Done_o,
    output logic [DATAWIDTH-1:0] ReadData_o,
    output logic                 Misaligned_o,
    output logic                 AccessFault_o,
    output logic                 MemReq_o,
    output logic                 MemWe_o,
    output logic [DATAWIDTH-1:0] MemAddr_o,
    output logic [3:0]           MemByteEn_o,
    output logic [DATAWIDTH-1:0] MemWData_o,
    input  logic                 MemAck_i,
    input  logic [DATAWIDTH-1:0] MemRData_i
);

    // Last BUSY cycle that may still wait; the counter reaches TIMEOUT as the unit leaves.
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    lsu_state_e r_state, w_state_d;

    logic                 r_we;
    logic [2:0]           r_funct3;
    logic [1:0]           r_addr_lo;
    logic [DATAWIDTH-1:0] r_addr;
    logic [DATAWIDTH-1:0] r_wdata;
    logic [3:0]           r_byte_en;
    logic [DATAWIDTH-1:0] r_rdata;
    logic [7:0]           r_wait_cnt;
    logic                 r_misaligned;
    logic                 r_fault;

    logic                 w_accept;
    logic                 w_legal;
    logic                 w_start;
    logic                 w_busy;
    logic                 w_timeout;
    logic [DATAWIDTH-1:0] w_store_data;
    logic [DATAWIDTH-1:0] w_load_data;

    assign w_busy    = (r_state == StBusy);
    assign w_accept  = (r_state == StIdle) && Valid_i && (MemRead_i ^ MemWrite_i);
    assign w_legal   = access_legal(MemRead_i, Funct3_i, Addr_i[1:0]);
    assign w_start   = w_accept && w_legal;
    assign w_timeout = w_busy && !MemAck_i && (r_wait_cnt == TimeoutLast);

    always_comb begin
        w_store_data = WriteData_i;
        case (Funct3_i[1:0])
            SizeByte: w_store_data = {(DATAWIDTH / 8){WriteData_i[7:0]}};
            SizeHalf: w_store_data = {(DATAWIDTH / 16){WriteData_i[15:0]}};
            default:  w_store_data = WriteData_i;
        endcase
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: if (w_start) w_state_d = StBusy;
            StBusy: begin
                if (MemAck_i) begin
                    w_state_d = StDone;
                end else if (w_timeout) begin
                    w_state_d = StIdle;
                end
            end
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    load_extend #(
        .DATAWIDTH (DATAWIDTH)
    ) u_load_extend (
        .i_word    (MemRData_i),
        .i_addr_lo (r_addr_lo),
        .i_funct3  (r_funct3),
        .o_data    (w_load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_we         <= 1'b0;
            r_funct3     <= 3'b000;
            r_addr_lo    <= 2'b00;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_byte_en    <= 4'b0000;
            r_rdata      <= '0;
            r_wait_cnt   <= 8'd0;
            r_misaligned <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_misaligned <= w_accept && !w_legal;
            r_fault      <= w_timeout;
            if (w_start) begin
                r_we       <= MemWrite_i;
                r_funct3   <= Funct3_i;
                r_addr_lo  <= Addr_i[1:0];
                r_addr     <= {Addr_i[DATAWIDTH-1:2], 2'b00};
                r_wdata    <= w_store_data;
                r_byte_en  <= byte_enable(Funct3_i[1:0], Addr_i[1:0]);
                r_wait_cnt <= 8'd0;
            end else if (w_busy && !MemAck_i) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
            if (w_busy && MemAck_i) begin
                r_rdata <= r_we ? '0 : w_load_data;
            end
        end
    end

    assign Ready_o       = (r_state == StIdle);
    assign Done_o        = (r_state == StDone);
    assign ReadData_o    = r_rdata;
    assign Misaligned_o  = r_misaligned;
    assign AccessFault_o = r_fault;
    assign MemReq_o      = w_busy;
    assign MemWe_o       = w_busy && r_we;
    assign MemAddr_o     = r_addr;
    assign MemByteEn_o   = r_byte_en;
    assign MemWData_o    = r_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized accesses
// compared against an arithmetic reference model.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        Valid_i;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic [2:0]  Funct3_i;
    logic [31:0] Addr_i;
    logic [31:0] WriteData_i;
    logic        MemAck_i;
    logic [31:0] MemRData_i;

    // a_*: instance with TIMEOUT=4, b_*: instance with the default TIMEOUT.
    logic        a_ready, a_done, a_mis, a_fault, a_req, a_we;
    logic [31:0] a_rdata, a_addr, a_wdata;
    logic [3:0]  a_be;
    logic        b_ready, b_done, b_mis, b_fault, b_req, b_we;
    logic [31:0] b_rdata, b_addr, b_wdata;
    logic [3:0]  b_be;

    logic        use_def;
    logic        s_ready, s_done, s_mis, s_fault, s_req, s_we;
    logic [31:0] s_rdata, s_addr, s_wdata;
    logic [3:0]  s_be;

    int n_pass;
    int n_total;

    load_store_unit #(
        .DATAWIDTH (32),
        .TIMEOUT   (4)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .Valid_i       (Valid_i),
        .MemRead_i     (MemRead_i),
        .MemWrite_i    (MemWrite_i),
        .Funct3_i      (Funct3_i),
        .Addr_i        (Addr_i),
        .WriteData_i   (WriteData_i),
        .Ready_o       (a_ready),
        .Done_o        (a_done),
        .ReadData_o    (a_rdata),
        .Misaligned_o  (a_mis),
        .AccessFault_o (a_fault),
        .MemReq_o      (a_req),
        .MemWe_o       (a_we),
        .MemAddr_o     (a_addr),
        .MemByteEn_o   (a_be),
        .MemWData_o    (a_wdata),
        .MemAck_i      (MemAck_i),
        .MemRData_i    (MemRData_i)
    );

    load_store_unit u_dut_def (
        .clk           (clk),
        .rst_n         (rst_n),
        .Valid_i       (Valid_i),
        .MemRead_i     (MemRead_i),
        .MemWrite_i    (MemWrite_i),
        .Funct3_i      (Funct3_i),
        .Addr_i        (Addr_i),
        .WriteData_i   (WriteData_i),
        .Ready_o       (b_ready),
        .Done_o        (b_done),
        .ReadData_o    (b_rdata),
        .Misaligned_o  (b_mis),
        .AccessFault_o (b_fault),
        .MemReq_o      (b_req),
        .MemWe_o       (b_we),
        .MemAddr_o     (b_addr),
        .MemByteEn_o   (b_be),
        .MemWData_o    (b_wdata),
        .MemAck_i      (MemAck_i),
        .MemRData_i    (MemRData_i)
    );

    assign s_ready = use_def ? b_ready : a_ready;
    assign s_done  = use_def ? b_done  : a_done;
    assign s_mis   = use_def ? b_mis   : a_mis;
    assign s_fault = use_def ? b_fault : a_fault;
    assign s_req   = use_def ? b_req   : a_req;
    assign s_we    = use_def ? b_we    : a_we;
    assign s_rdata = use_def ? b_rdata : a_rdata;
    assign s_addr  = use_def ? b_addr  : a_addr;
    assign s_wdata = use_def ? b_wdata : a_wdata;
    assign s_be    = use_def ? b_be    : a_be;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: access size in bytes, 0 for unused encodings.
    function automatic int unsigned m_size(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic logic m_legal(input logic ld, input logic [2:0] f3,
                                     input logic [31:0] addr);
        int unsigned sz;
        sz = m_size(f3);
        if (sz == 0) return 1'b0;
        if (!ld && f3 > 3'd2) return 1'b0;
        return (addr % sz) == 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] addr);
        int unsigned sz;
        sz = m_size(f3);
        return 4'(((1 << sz) - 1) << (addr % 4));
    endfunction

    function automatic logic [31:0] m_store(input logic [2:0] f3, input logic [31:0] wd);
        int unsigned sz;
        logic [31:0] r;
        sz = m_size(f3);
        r  = '0;
        for (int lane = 0; lane < 4; lane++) begin
            r[lane*8 +: 8] = wd[(lane % sz)*8 +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] rd);
        int unsigned sz;
        logic [63:0] v;
        logic [63:0] mask;
        sz   = m_size(f3);
        v    = {32'd0, rd} >> (8 * (addr % 4));
        mask = (64'd1 << (8 * sz)) - 64'd1;
        v    = v & mask;
        if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    task automatic do_access(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [31:0] rd, input int delay,
                             input string tag);
        logic legal;
        legal = m_legal(ld, f3, addr);
        check({tag, ":ready_in"}, 32'(s_ready), 32'd1);
        Valid_i     = 1'b1;
        MemRead_i   = ld;
        MemWrite_i  = !ld;
        Funct3_i    = f3;
        Addr_i      = addr;
        WriteData_i = wd;
        step();
        Valid_i    = 1'b0;
        MemRead_i  = 1'b0;
        MemWrite_i = 1'b0;
        Addr_i     = $urandom;
        if (!legal) begin
            check({tag, ":mis"}, 32'(s_mis), 32'd1);
            check({tag, ":mis_req"}, 32'(s_req), 32'd0);
            check({tag, ":mis_ready"}, 32'(s_ready), 32'd1);
            step();
            check({tag, ":mis_once"}, 32'(s_mis), 32'd0);
            check({tag, ":mis_req2"}, 32'(s_req), 32'd0);
            return;
        end
        for (int k = 0; k <= delay; k++) begin
            check({tag, ":req"}, 32'(s_req), 32'd1);
            check({tag, ":busy"}, 32'(s_ready), 32'd0);
            check({tag, ":addr"}, s_addr, addr & 32'hFFFF_FFFC);
            if (k == 0) begin
                check({tag, ":we"}, 32'(s_we), 32'(!ld));
                check({tag, ":be"}, 32'(s_be), 32'(m_be(f3, addr)));
                if (!ld) check({tag, ":wdata"}, s_wdata, m_store(f3, wd));
            end
            if (k == delay) begin
                MemAck_i   = 1'b1;
                MemRData_i = rd;
            end else begin
                MemRData_i = $urandom;
            end
            step();
        end
        MemAck_i   = 1'b0;
        MemRData_i = $urandom;
        check({tag, ":done"}, 32'(s_done), 32'd1);
        check({tag, ":rdata"}, s_rdata, ld ? m_load(f3, addr, rd) : 32'd0);
        check({tag, ":done_fault"}, 32'(s_fault), 32'd0);
        check({tag, ":done_req"}, 32'(s_req), 32'd0);
        step();
        check({tag, ":done_once"}, 32'(s_done), 32'd0);
        check({tag, ":ready_out"}, 32'(s_ready), 32'd1);
    endtask

    initial begin
        n_pass      = 0;
        n_total     = 0;
        use_def     = 1'b0;
        rst_n       = 1'b1;
        Valid_i     = 1'b0;
        MemRead_i   = 1'b0;
        MemWrite_i  = 1'b0;
        Funct3_i    = 3'b000;
        Addr_i      = '0;
        WriteData_i = '0;
        MemAck_i    = 1'b0;
        MemRData_i  = '0;

        #2 rst_n = 1'b0;
        #1;
        check("rst_ready", 32'(a_ready), 32'd1);
        check("rst_req", 32'(a_req), 32'd0);
        check("rst_we", 32'(a_we), 32'd0);
        check("rst_done", 32'(a_done), 32'd0);
        check("rst_mis", 32'(a_mis), 32'd0);
        check("rst_fault", 32'(a_fault), 32'd0);
        check("rst_rdata", a_rdata, 32'd0);
        check("rst_addr", a_addr, 32'd0);
        check("rst_wdata", a_wdata, 32'd0);
        check("rst_be", 32'(a_be), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        do_access(1'b1, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_FF00, 0, "lb_1003");
        do_access(1'b0, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'h5555_5555, 0, "sh_2002");
        do_access(1'b1, 3'b010, 32'h0000_3001, 32'h0, 32'h0, 0, "lw_3001");
        do_access(1'b0, 3'b100, 32'h0000_3000, 32'h0, 32'h0, 0, "s_illegal");
        do_access(1'b1, 3'b010, 32'h0000_3004, 32'h0, 32'hCAFE_F00D, 3, "ack_at_limit");

        use_def = 1'b1;
        do_access(1'b1, 3'b101, 32'h0000_4002, 32'h0, 32'hBEEF_0000, 5, "lhu_4002");
        use_def = 1'b0;

        // Accesses without the single-direction qualifier are no-ops.
        Valid_i = 1'b1; MemRead_i = 1'b1; MemWrite_i = 1'b1; Funct3_i = 3'b010;
        Addr_i  = 32'h0000_0100;
        step();
        Valid_i = 1'b1; MemRead_i = 1'b0; MemWrite_i = 1'b0;
        check("noop_both_req", 32'(a_req), 32'd0);
        check("noop_both_mis", 32'(a_mis), 32'd0);
        step();
        Valid_i = 1'b0;
        check("noop_none_req", 32'(a_req), 32'd0);
        check("noop_none_ready", 32'(a_ready), 32'd1);

        // Timeout on the TIMEOUT=4 instance.
        Valid_i = 1'b1; MemRead_i = 1'b1; Funct3_i = 3'b010; Addr_i = 32'h0000_0200;
        step();
        Valid_i = 1'b0; MemRead_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check("to_req", 32'(a_req), 32'd1);
            check("to_nofault", 32'(a_fault), 32'd0);
            step();
        end
        check("to_req_drop", 32'(a_req), 32'd0);
        check("to_fault", 32'(a_fault), 32'd1);
        check("to_ready", 32'(a_ready), 32'd1);
        check("to_nodone", 32'(a_done), 32'd0);
        step();
        check("to_fault_once", 32'(a_fault), 32'd0);
        MemAck_i = 1'b1; MemRData_i = 32'h1111_2222;
        step();
        MemAck_i = 1'b0;
        check("late_ack_done", 32'(a_done), 32'd0);
        check("late_ack_ready", 32'(a_ready), 32'd1);
        step();

        // Reset while BUSY abandons the access silently.
        Valid_i = 1'b1; MemWrite_i = 1'b1; Funct3_i = 3'b010; Addr_i = 32'h0000_5000;
        WriteData_i = 32'hA5A5_5A5A;
        step();
        Valid_i = 1'b0; MemWrite_i = 1'b0;
        check("rb_req", 32'(a_req), 32'd1);
        step();
        rst_n = 1'b0;
        #1;
        check("rb_req_now", 32'(a_req), 32'd0);
        check("rb_ready_now", 32'(a_ready), 32'd1);
        check("rb_be_now", 32'(a_be), 32'd0);
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            check("rb_nodone", 32'(a_done), 32'd0);
            check("rb_nofault", 32'(a_fault), 32'd0);
            step();
        end
        do_access(1'b0, 3'b010, 32'h0000_6008, 32'hDEAD_BEEF, 32'h0, 1, "sw_after_rst");

        for (int i = 0; i < 40; i++) begin
            do_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                      $urandom, int'($urandom_range(0, 3)), "rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter DATAWIDTH, default 32: data and address width.
REQ-002 Parameter TIMEOUT, default 255: maximum cycles to wait for MemAck_i before faulting.
REQ-003 One clock, clk; reset is asynchronous and active-low, rst_n.
REQ-004 Ports, in order (name, direction, width, meaning):
- clk  in  1: clock, rising edge.
- rst_n  in  1: asynchronous active-low reset.
- Valid_i  in  1: execute stage presents an access this cycle.
- MemRead_i  in  1: load request.
- MemWrite_i  in  1: store request.
- Funct3_i  in  3: access width and signedness (RV32I encoding).
- Addr_i  in  DATAWIDTH: byte address, the ALUResult of the execute stage.
- WriteData_i  in  DATAWIDTH: store data, rs2.
- Ready_o  out  1: unit idle, can accept an access.
- Done_o  out  1: one-cycle pulse, access complete.
- ReadData_o  out  DATAWIDTH: extended load data, valid while Done_o=1.
- Misaligned_o  out  1: one-cycle pulse, misaligned or illegal access rejected.
- AccessFault_o  out  1: one-cycle pulse, memory timeout.
- MemReq_o  out  1: memory request.
- MemWe_o  out  1: memory write enable.
- MemAddr_o  out  DATAWIDTH: word-aligned address, Addr_i with bits [1:0] forced to 0.
- MemByteEn_o  out  4: byte lane enables.
- MemWData_o  out  DATAWIDTH: lane-replicated store data.
- MemAck_i  in  1: memory completes the request this cycle.
- MemRData_i  in  DATAWIDTH: read word, valid with MemAck_i.

Function
REQ-005 FSM states: IDLE, BUSY, DONE. Ready_o = (state == IDLE), combinational.
REQ-006 An access is accepted in IDLE when Valid_i=1 and exactly one of MemRead_i/MemWrite_i is 1. Valid_i with both or neither is a no-op: state stays IDLE, no pulse.
REQ-007 Legal Funct3_i values:
- Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Stores: 000 SB, 001 SH, 010 SW.
- Any other value is illegal.
REQ-008 Alignment rules: halfword needs Addr_i[0]=0; word needs Addr_i[1:0]=00.
REQ-009 An accepted access that is misaligned or illegal pulses Misaligned_o on the next cycle, issues no memory request, and leaves the state in IDLE.
REQ-010 An accepted legal access latches address, data, Funct3_i and direction, then moves to BUSY on the next edge.
REQ-011 In BUSY, MemReq_o=1 and MemWe_o, MemAddr_o, MemByteEn_o and MemWData_o are held stable from the latched values until MemAck_i.
REQ-012 Byte enables:
- Byte access: 0001 << Addr[1:0].
- Halfword access: 0011 << Addr[1:0].
- Word access: 1111.
REQ-013 Store data: byte replicated to all 4 lanes, halfword replicated to both halves, word unchanged.
REQ-014 MemAck_i in BUSY moves to DONE.
- For a load, ReadData_o registers the selected lane of MemRData_i, sign-extended for LB/LH and zero-extended for LBU/LHU; LW passes the word unchanged.
- For a store, ReadData_o = 0.
REQ-015 DONE lasts exactly one cycle with Done_o=1, then returns to IDLE. Minimum latency from acceptance to Done_o is 2 cycles, reached when MemAck_i is asserted in the first BUSY cycle.
REQ-016 An 8-bit wait counter clears on entry to BUSY and increments each BUSY cycle without MemAck_i.
REQ-017 When the counter reaches TIMEOUT: MemReq_o deasserts, AccessFault_o pulses for one cycle, state returns to IDLE, Done_o is not asserted. MemAck_i in the same cycle takes priority over the timeout.
REQ-018 Valid_i is ignored outside IDLE. The upstream stage stalls while Ready_o=0.
REQ-019 MemAck_i outside BUSY is ignored.

Reset
REQ-020 rst_n low immediately forces:
- State IDLE, Ready_o=1.
- MemReq_o, MemWe_o, Done_o, Misaligned_o, AccessFault_o = 0.
- ReadData_o, MemAddr_o, MemWData_o, MemByteEn_o and the counter = 0.
REQ-021 Reset asserted in BUSY abandons the access with no completion or fault pulse. The first edge after release is treated as IDLE.

Structure
REQ-022 Package lsu_pkg holds the state enum, the Funct3 load/store width encodings, and the default TIMEOUT constant.
REQ-023 The combinational lane select and sign/zero extension form one sub-module, load_extend (inputs: word, Addr[1:0], Funct3; output: extended data).

Verification
REQ-024 LB at Addr 0x1003, MemRData_i=0x80FF_FF00, ack in the first BUSY cycle -> MemByteEn_o=1000, MemAddr_o=0x1000, ReadData_o=0xFFFF_FF80, Done_o 2 cycles after acceptance.
REQ-025 SH at Addr 0x2002, WriteData_i=0x1234_ABCD -> MemWe_o=1, MemByteEn_o=1100, MemWData_o=0xABCD_ABCD; after ack, Done_o=1 and ReadData_o=0.
REQ-026 LW at Addr 0x3001 -> Misaligned_o pulses once, MemReq_o stays 0, Ready_o stays 1.
REQ-027 LHU at Addr 0x4002 with ack delayed 5 cycles, MemRData_i=0xBEEF_0000 -> MemReq_o and MemAddr_o stable for 5 cycles, ReadData_o=0x0000_BEEF.
REQ-028 Load with no ack, TIMEOUT=4 -> AccessFault_o pulses after 4 BUSY cycles, no Done_o, Ready_o returns to 1.
REQ-029 rst_n pulsed low during BUSY -> MemReq_o=0 immediately, no Done_o or AccessFault_o; after release, a new SW completes normally.
